timer_sequencer: RTL
====================

# timer_sequencer

Sequencing controller for the four-digit BCD mm:ss time counter built from per-digit add/sub stages. It owns the run/pause/done state machine and the count-tick prescaler. It issues one increment or decrement per tick and ripples carry/borrow across seconds-ones (0-9), seconds-tens (0-5), minutes-ones (0-9) and minutes-tens (0-5). It sits between the debounced front-panel pulses and the seven-segment display driver.

## Interface
- TICK_DIV, 100: clock cycles per count tick; must be ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begin or resume counting.
- stop  in  1  single-cycle pulse; pause counting.
- load  in  1  single-cycle pulse; load `load_val` into the digits.
- load_val  in  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- mode_down  in  1  direction: 1 counts down, 0 counts up; sampled when `start` is accepted.
- digits  out  16  current BCD value, same packing as `load_val`.
- running  out  1  high while in COUNT.
- done  out  1  high while in DONE.
- tick  out  1  one-cycle pulse on each cycle where `digits` changed by a count.
- wrap  out  1  one-cycle pulse when an up-count rolls 59:59 to 00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, COUNT, PAUSED, DONE.
- Reset values: state=IDLE, digits=0, prescaler=0, dir=up, all outputs 0.
- **IDLE**
  - `start` → COUNT; latch `dir` from `mode_down`; clear prescaler.
- **COUNT**
  - The prescaler counts 0..TICK_DIV-1.
  - When the prescaler reaches its terminal count it returns to 0 and one count step is applied.
  - `stop` → PAUSED; the prescaler holds its value.
  - `start` is ignored.
- **PAUSED**
  - `start` → COUNT; re-latch `dir`; the prescaler resumes from its held value.
- **DONE**
  - `start` is ignored.
  - `load` (when accepted) → IDLE.
- **Simultaneous events:** `stop` beats `start`; `load` beats `start`.
- **Load**
  - Accepted only in IDLE, PAUSED and DONE.
  - In COUNT it is silently ignored: no `load_err`.
  - A load is rejected if any ones digit is greater than 9 or any tens digit is greater than 5. On rejection `load_err` pulses and the digits are unchanged.
  - An accepted load in PAUSED stays in PAUSED and clears the prescaler.
- **Up step**
  - Increment sec_ones. A digit at its maximum goes to 0 and carries into the next digit.
  - A carry out of min_tens wraps the value to 00:00 and pulses `wrap`.
- **Down step**
  - Decrement sec_ones. A digit at 0 goes to its maximum and borrows from the next digit.
  - A step that lands on 00:00 moves to DONE in the same edge.
- **Down start at 00:00:** the transition goes directly to DONE with no step and no `tick`.
- **Invariant:** illegal BCD never appears on `digits`.

## Timing
- `start` is accepted at edge E. The first step lands at edge E+TICK_DIV, then repeats every TICK_DIV cycles.
- `tick`, `wrap`, `done` and `digits` are all registered and update on the same edge as the step.
- `stop` at edge S: no step occurs at S, even if the prescaler was terminal in that cycle.
- `load_err` is registered and asserted in the cycle after the `load` pulse.
- `rst` asserted during any state forces the reset values at the next edge. It overrides all other inputs.

## Structure
- **Package `timer_pkg`:** state enum (`timer_state_t`), constants `ONES_MAX=9` and `TENS_MAX=5`, and a BCD digit typedef (`logic [3:0]`).
- **Sub-module `bcd_digit_step`:**
  - Parameter: `MAX`.
  - Inputs: digit, `en`, `down`.
  - Outputs: next digit and carry/borrow out.
  - Purely combinational.
  - Instantiated four times; each carry/borrow out feeds the next instance's `en`.
- The top level holds the FSM, prescaler, digit registers and load validation.

## Test plan
- **Up ripple (TICK_DIV=4):** load 09:59, start with mode_down=0 → after 4 cycles `digits`=10:00, `tick`=1 for one cycle; after a further 4 cycles `digits`=10:01.
- **Up wrap:** load 59:59, start up → next step gives 00:00, `wrap`=1 for one cycle, state stays COUNT.
- **Down to done:** load 00:02, start with mode_down=1 → 00:01, then 00:00 with `done`=1 and `running`=0; the prescaler and digits stop; a later `start` is ignored.
- **Pause/resume:** start, `stop` after 2 cycles, hold 10 cycles with no change, `start` → next step arrives 2 cycles later (prescaler held).
- **Invalid and blocked loads:** load 0x6000 (min_tens=6) in IDLE → `load_err` pulse, digits unchanged; any load during COUNT → ignored, no `load_err`.
- **Reset mid-run:** `rst` during COUNT at 12:34 → next edge shows 00:00, IDLE, all flags 0; `start`+`stop` in the same cycle from IDLE → stays IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer sequencer.
// Holds the controller state encoding, digit limits and load validation.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ONES_MAX = 4'd9;
    localparam bcd_digit_t TENS_MAX = 4'd5;

    // Packing is {min_tens, min_ones, sec_tens, sec_ones}.
    function automatic logic bcd_time_valid(input logic [15:0] v);
        return (v[15:12] <= TENS_MAX) && (v[11:8] <= ONES_MAX) &&
               (v[7:4]   <= TENS_MAX) && (v[3:0]  <= ONES_MAX);
    endfunction

endpackage

// File: rtl/timer_sequencer_digit.sv
// One BCD digit add/sub stage: steps by one when enabled and
// reports carry (up) or borrow (down) for the next more-significant digit.
module bcd_digit_step
    import timer_pkg::*;
#(
    parameter bcd_digit_t MAX = ONES_MAX
)
(
    input  bcd_digit_t digit_i,
    input  logic       en_i,
    input  logic       down_i,
    output bcd_digit_t digit_o,
    output logic       carry_o
);

    // Next digit value and carry/borrow out.
    always_comb begin
        digit_o = digit_i;
        carry_o = 1'b0;
        if (!en_i) begin
            digit_o = digit_i;
        end else if (down_i) begin
            if (digit_i == 4'd0) begin
                digit_o = MAX;
                carry_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end else begin
            if (digit_i >= MAX) begin
                digit_o = 4'd0;
                carry_o = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Run/pause/done controller for a four-digit BCD mm:ss counter, with the
// tick prescaler, digit registers and load validation.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        mode_down,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        tick,
    output logic        wrap,
    output logic        load_err
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

    timer_state_t  state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   digits_q;
    logic          dir_down_q;
    logic          running_q, done_q, tick_q, wrap_q, load_err_q;

    logic [15:0]   step_digits_d;
    logic [3:0]    carry_s;
    logic          load_ok_s, start_ok_s, start_to_done_s;

    bcd_digit_step #(.MAX(ONES_MAX)) u_sec_ones (
        .digit_i(digits_q[3:0]),   .en_i(1'b1),       .down_i(dir_down_q),
        .digit_o(step_digits_d[3:0]),   .carry_o(carry_s[0]));
    bcd_digit_step #(.MAX(TENS_MAX)) u_sec_tens (
        .digit_i(digits_q[7:4]),   .en_i(carry_s[0]), .down_i(dir_down_q),
        .digit_o(step_digits_d[7:4]),   .carry_o(carry_s[1]));
    bcd_digit_step #(.MAX(ONES_MAX)) u_min_ones (
        .digit_i(digits_q[11:8]),  .en_i(carry_s[1]), .down_i(dir_down_q),
        .digit_o(step_digits_d[11:8]),  .carry_o(carry_s[2]));
    bcd_digit_step #(.MAX(TENS_MAX)) u_min_tens (
        .digit_i(digits_q[15:12]), .en_i(carry_s[2]), .down_i(dir_down_q),
        .digit_o(step_digits_d[15:12]), .carry_o(carry_s[3]));

    // Stop outranks start; a down start from 00:00 has nothing to count.
    always_comb begin
        load_ok_s       = bcd_time_valid(load_val);
        start_ok_s      = start && !stop;
        start_to_done_s = mode_down && (digits_q == 16'h0000);
    end

    // Controller FSM, prescaler, digit registers and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            digits_q   <= 16'h0000;
            dir_down_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (load) begin
                        if (load_ok_s) begin
                            digits_q <= load_val;
                            presc_q  <= '0;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end else if (start_ok_s) begin
                        dir_down_q <= mode_down;
                        if (state_q == ST_IDLE) begin
                            presc_q <= '0;
                        end
                        if (start_to_done_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_COUNT;
                            running_q <= 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (stop) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end else if (presc_q == PRESC_TC) begin
                        presc_q  <= '0;
                        digits_q <= step_digits_d;
                        tick_q   <= 1'b1;
                        wrap_q   <= !dir_down_q && carry_s[3];
                        if (dir_down_q && (step_digits_d == 16'h0000)) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        if (load_ok_s) begin
                            digits_q <= load_val;
                            state_q  <= ST_IDLE;
                            done_q   <= 1'b0;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign done     = done_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule
